fp_request_arbiter: RTL and testbench

Shares the single 16-bit half-precision `floatingPoint` unit (add/sub/mul/div, fixed pipeline latency) between several manipulator computation requesters, such as the kinematics and trajectory engines. It accepts one operation per cycle under round-robin arbitration and drives the unit's operand and op-select inputs. It tracks each in-flight operation with a tag pipeline matched to the unit latency and returns each result to the requester that issued it.

---
 rtl/fp_ctrl_pkg.sv | 27 ++
 rtl/fp_rr_arbiter.sv | 46 ++++
 rtl/fp_request_arbiter.sv | 103 ++++++++++
 tb/tb_fp_request_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_ctrl_pkg
// Brief    : Shared types and constants for the shared FP unit front end.
// Revision : 1.0 - initial release
// ============================================================================
package fp_ctrl_pkg;

    localparam int FP_DATA_W          = 16;
    localparam int FP_DEFAULT_LATENCY = 3;
    // Wide enough for the largest supported requester count (8).
    localparam int FP_IDX_W           = 3;

    typedef enum logic [1:0] {
        FP_ADD = 2'b00,
        FP_SUB = 2'b01,
        FP_MUL = 2'b10,
        FP_DIV = 2'b11
    } fp_op_e;

    typedef struct packed {
        logic                valid;
        logic [FP_IDX_W-1:0] index;
    } fp_tag_t;

endpackage
`default_nettype wire

// File: rtl/fp_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_rr_arbiter
// Brief    : Combinational round-robin picker; the pointer lives in the parent.
// Revision : 1.0 - initial release
// ============================================================================
module fp_rr_arbiter
    import fp_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [FP_IDX_W-1:0] i_ptr,
    output logic [NUM_REQ-1:0]  o_grant,
    output logic [FP_IDX_W-1:0] o_grant_idx,
    output logic                o_grant_vld,
    output logic [FP_IDX_W-1:0] o_next_ptr
);

    int w_pos;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_vld = 1'b0;
        o_next_ptr  = i_ptr;
        w_pos       = 0;
        // Walk offsets from the pointer; the first active request wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!o_grant_vld && (i == w_pos) && i_req[i]) begin
                    o_grant_vld = 1'b1;
                    o_grant[i]  = 1'b1;
                    o_grant_idx = FP_IDX_W'(i);
                    o_next_ptr  = (i == NUM_REQ - 1) ? '0 : FP_IDX_W'(i + 1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_request_arbiter
// Brief    : Round-robin sharing of one pipelined half-precision FP unit with
//            per-requester result return through a latency-matched tag pipe.
// Revision : 1.0 - initial release
// ============================================================================
module fp_request_arbiter
    import fp_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = FP_DATA_W,
    parameter int FP_LATENCY = FP_DEFAULT_LATENCY
) (
    input  logic                      clk,
    input  logic                      areset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]      req_op,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [DATA_W-1:0]         fp_a,
    output logic [DATA_W-1:0]         fp_b,
    output logic [1:0]                fp_op,
    input  logic [DATA_W-1:0]         fp_result,
    output logic                      busy
);

    logic [NUM_REQ-1:0]  r_pending;
    logic [FP_IDX_W-1:0] r_ptr;
    fp_tag_t             r_tag [0:FP_LATENCY];

    logic [NUM_REQ-1:0]  w_req;
    logic [NUM_REQ-1:0]  w_grant;
    logic [FP_IDX_W-1:0] w_grant_idx;
    logic                w_grant_vld;
    logic [FP_IDX_W-1:0] w_next_ptr;
    logic [NUM_REQ-1:0]  w_clr;

    assign req_ready = ~r_pending;
    assign busy      = |r_pending;
    assign w_req     = req_valid & ~r_pending;

    fp_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_req       (w_req),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_vld (w_grant_vld),
        .o_next_ptr  (w_next_ptr)
    );

    // Last tag stage lines up with fp_result for the op it describes.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_clr[i] = r_tag[FP_LATENCY].valid &&
                       (r_tag[FP_LATENCY].index == FP_IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            r_pending <= '0;
            r_ptr     <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            fp_a      <= '0;
            fp_b      <= '0;
            fp_op     <= FP_ADD;
            for (int k = 0; k <= FP_LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_grant;
            rsp_valid <= w_clr;
            if (r_tag[FP_LATENCY].valid) begin
                rsp_data <= fp_result;
            end
            if (w_grant_vld) begin
                r_ptr <= w_next_ptr;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i]) begin
                    fp_a  <= req_a[i*DATA_W +: DATA_W];
                    fp_b  <= req_b[i*DATA_W +: DATA_W];
                    fp_op <= req_op[i*2 +: 2];
                end
            end
            r_tag[0].valid <= w_grant_vld;
            r_tag[0].index <= w_grant_idx;
            for (int k = 1; k <= FP_LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_request_arbiter
// Brief    : Directed self-checking bench with a 3-cycle FP unit stand-in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_request_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_W     = 16;
    localparam int FP_LATENCY = 3;

    logic                      clk = 1'b0;
    logic                      areset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*2-1:0]      req_op;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [DATA_W-1:0]         fp_a;
    logic [DATA_W-1:0]         fp_b;
    logic [1:0]                fp_op;
    logic [DATA_W-1:0]         fp_result;
    logic                      busy;

    int n_pass  = 0;
    int n_total = 0;

    fp_request_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .FP_LATENCY (FP_LATENCY)
    ) dut (
        .clk       (clk),
        .areset    (areset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .fp_a      (fp_a),
        .fp_b      (fp_b),
        .fp_op     (fp_op),
        .fp_result (fp_result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Stand-in FP unit: exact half-precision answers for 2.5 op 2.5, XOR otherwise.
    function automatic logic [15:0] fp_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic [1:0] op);
        if (a == 16'h4100 && b == 16'h4100) begin
            case (op)
                2'b00:   return 16'h4500;
                2'b01:   return 16'h0000;
                2'b10:   return 16'h4640;
                default: return 16'h3C00;
            endcase
        end
        return a ^ b;
    endfunction

    logic [15:0] s1, s2, s3;
    always @(posedge clk) begin
        s1 <= fp_model(fp_a, fp_b, fp_op);
        s2 <= s1;
        s3 <= s2;
    end
    assign fp_result = s3;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic [1:0] op);
        req_a[i*DATA_W +: DATA_W] = a;
        req_b[i*DATA_W +: DATA_W] = b;
        req_op[i*2 +: 2]          = op;
    endtask

    task automatic do_reset;
        areset    = 1'b1;
        req_valid = '0;
        tick;
        tick;
        areset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_total++; if (req_ready !== 4'b1111) $display("FAIL reset_ready got %b want 1111", req_ready); else n_pass++;
        n_total++; if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 16'h0000) $display("FAIL reset_rsp_data got %h want 0000", rsp_data); else n_pass++;
        n_total++; if (fp_a !== 16'h0000) $display("FAIL reset_fp_a got %h want 0000", fp_a); else n_pass++;
        n_total++; if (fp_b !== 16'h0000) $display("FAIL reset_fp_b got %h want 0000", fp_b); else n_pass++;
        n_total++; if (fp_op !== 2'b00) $display("FAIL reset_fp_op got %b want 00", fp_op); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_single_add;
        logic       exp_busy;
        logic [3:0] exp_rsp;
        do_reset;
        set_req(0, 16'h4100, 16'h4100, 2'b00);
        req_valid = 4'b0001;
        for (int c = 1; c <= 6; c++) begin
            tick;
            req_valid = '0;
            exp_busy = (c <= 4);
            exp_rsp  = (c == 5) ? 4'b0001 : 4'b0000;
            n_total++; if (busy !== exp_busy) $display("FAIL single_busy c%0d got %b want %b", c, busy, exp_busy); else n_pass++;
            n_total++; if (rsp_valid !== exp_rsp) $display("FAIL single_rsp_valid c%0d got %b want %b", c, rsp_valid, exp_rsp); else n_pass++;
            if (c == 1) begin
                n_total++; if (fp_a !== 16'h4100) $display("FAIL single_fp_a got %h want 4100", fp_a); else n_pass++;
                n_total++; if (fp_b !== 16'h4100) $display("FAIL single_fp_b got %h want 4100", fp_b); else n_pass++;
                n_total++; if (req_ready !== 4'b1110) $display("FAIL single_ready got %b want 1110", req_ready); else n_pass++;
            end
            if (c == 5) begin
                n_total++; if (rsp_data !== 16'h4500) $display("FAIL single_rsp_data got %h want 4500", rsp_data); else n_pass++;
                n_total++; if (req_ready !== 4'b1111) $display("FAIL single_ready_back got %b want 1111", req_ready); else n_pass++;
            end
        end
    endtask

    task automatic test_all_four;
        logic [15:0] exp_data [4] = '{16'h4500, 16'h0000, 16'h4640, 16'h3C00};
        logic [3:0]  exp_rdy  [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
        logic [3:0]  exp_rsp;
        do_reset;
        for (int i = 0; i < 4; i++) set_req(i, 16'h4100, 16'h4100, 2'(i));
        req_valid = 4'b1111;
        for (int c = 1; c <= 9; c++) begin
            tick;
            exp_rsp = (c >= 5 && c <= 8) ? 4'(1 << (c - 5)) : 4'b0000;
            n_total++; if (rsp_valid !== exp_rsp) $display("FAIL all4_rsp_valid c%0d got %b want %b", c, rsp_valid, exp_rsp); else n_pass++;
            if (c <= 4) begin
                req_valid[c-1] = 1'b0;
                n_total++; if (fp_op !== 2'(c - 1)) $display("FAIL all4_grant c%0d fp_op got %b want %0d", c, fp_op, c - 1); else n_pass++;
                n_total++; if (req_ready !== exp_rdy[c-1]) $display("FAIL all4_ready c%0d got %b want %b", c, req_ready, exp_rdy[c-1]); else n_pass++;
            end
            if (c >= 5 && c <= 8) begin
                n_total++; if (rsp_data !== exp_data[c-5]) $display("FAIL all4_rsp_data c%0d got %h want %h", c, rsp_data, exp_data[c-5]); else n_pass++;
            end
        end
    endtask

    task automatic test_fairness;
        logic [3:0] prev_rdy, fell;
        int last_g = -1;
        int bad = 0, g0 = 0, g1 = 0, done0 = 0, done1 = 0, diff;
        do_reset;
        set_req(0, 16'h4100, 16'h4100, 2'b00);
        set_req(1, 16'h4100, 16'h4100, 2'b01);
        req_valid = 4'b0011;
        prev_rdy  = req_ready;
        for (int c = 1; c <= 50; c++) begin
            tick;
            fell = prev_rdy & ~req_ready;
            if (fell[0] && fell[1]) bad++;
            if (fell[0]) begin g0++; if (last_g == 0) bad++; last_g = 0; end
            if (fell[1]) begin g1++; if (last_g == 1) bad++; last_g = 1; end
            if (rsp_valid[0]) done0++;
            if (rsp_valid[1]) done1++;
            prev_rdy = req_ready;
        end
        req_valid = '0;
        diff = (done0 > done1) ? done0 - done1 : done1 - done0;
        n_total++; if (bad !== 0) $display("FAIL fair_alternate violations got %0d want 0", bad); else n_pass++;
        n_total++; if (g0 !== 10) $display("FAIL fair_grants0 got %0d want 10", g0); else n_pass++;
        n_total++; if (g1 !== 10) $display("FAIL fair_grants1 got %0d want 10", g1); else n_pass++;
        n_total++; if (done0 !== 10) $display("FAIL fair_done0 got %0d want 10", done0); else n_pass++;
        n_total++; if (done1 !== 9) $display("FAIL fair_done1 got %0d want 9", done1); else n_pass++;
        n_total++; if ((diff <= 1) !== 1'b1) $display("FAIL fair_diff got %0d want <=1", diff); else n_pass++;
        for (int c = 0; c < 8; c++) tick;
    endtask

    task automatic test_back_to_back;
        logic       exp_rdy0;
        logic [3:0] exp_rsp;
        do_reset;
        set_req(0, 16'h4100, 16'h4100, 2'b00);
        req_valid = 4'b0001;
        for (int c = 1; c <= 10; c++) begin
            tick;
            exp_rdy0 = (c == 5 || c == 10);
            exp_rsp  = exp_rdy0 ? 4'b0001 : 4'b0000;
            n_total++; if (req_ready[0] !== exp_rdy0) $display("FAIL b2b_ready0 c%0d got %b want %b", c, req_ready[0], exp_rdy0); else n_pass++;
            n_total++; if (rsp_valid !== exp_rsp) $display("FAIL b2b_rsp_valid c%0d got %b want %b", c, rsp_valid, exp_rsp); else n_pass++;
            if (c == 10) begin
                n_total++; if (rsp_data !== 16'h4500) $display("FAIL b2b_rsp_data got %h want 4500", rsp_data); else n_pass++;
            end
        end
        req_valid = '0;
        for (int c = 0; c < 7; c++) tick;
    endtask

    task automatic test_reset_midflight;
        do_reset;
        set_req(2, 16'h4100, 16'h4100, 2'b01);
        req_valid = 4'b0100;
        tick;
        req_valid = '0;
        tick;
        areset = 1'b1;
        tick;
        areset = 1'b0;
        n_total++; if (req_ready !== 4'b1111) $display("FAIL midrst_ready got %b want 1111", req_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
        for (int c = 3; c <= 10; c++) begin
            n_total++; if (rsp_valid !== 4'b0000) $display("FAIL midrst_no_rsp c%0d got %b want 0000", c, rsp_valid); else n_pass++;
            tick;
        end
        for (int i = 0; i < 4; i++) set_req(i, 16'h1234 + 16'(i), 16'h0101, 2'(i));
        req_valid = 4'b1111;
        tick;
        req_valid = '0;
        n_total++; if (req_ready !== 4'b1110) $display("FAIL midrst_regrant got %b want 1110", req_ready); else n_pass++;
        n_total++; if (fp_a !== 16'h1234) $display("FAIL midrst_fp_a got %h want 1234", fp_a); else n_pass++;
        n_total++; if (fp_b !== 16'h0101) $display("FAIL midrst_fp_b got %h want 0101", fp_b); else n_pass++;
        for (int c = 2; c <= 5; c++) tick;
        n_total++; if (rsp_valid !== 4'b0001) $display("FAIL midrst_rsp_valid got %b want 0001", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 16'h1335) $display("FAIL midrst_rsp_data got %h want 1335", rsp_data); else n_pass++;
        tick;
        tick;
    endtask

    task automatic test_idle;
        do_reset;
        set_req(1, 16'h4100, 16'h4100, 2'b10);
        req_valid = 4'b0010;
        tick;
        req_valid = '0;
        for (int c = 2; c <= 5; c++) tick;
        n_total++; if (rsp_valid !== 4'b0010) $display("FAIL idle_rsp_valid got %b want 0010", rsp_valid); else n_pass++;
        n_total++; if (rsp_data !== 16'h4640) $display("FAIL idle_rsp_data got %h want 4640", rsp_data); else n_pass++;
        for (int c = 6; c <= 25; c++) begin
            tick;
            n_total++; if (fp_a !== 16'h4100) $display("FAIL idle_fp_a c%0d got %h want 4100", c, fp_a); else n_pass++;
            n_total++; if (fp_b !== 16'h4100) $display("FAIL idle_fp_b c%0d got %h want 4100", c, fp_b); else n_pass++;
            n_total++; if (fp_op !== 2'b10) $display("FAIL idle_fp_op c%0d got %b want 10", c, fp_op); else n_pass++;
            n_total++; if (rsp_valid !== 4'b0000) $display("FAIL idle_rsp_valid c%0d got %b want 0000", c, rsp_valid); else n_pass++;
            n_total++; if (busy !== 1'b0) $display("FAIL idle_busy c%0d got %b want 0", c, busy); else n_pass++;
        end
    endtask

    initial begin
        areset    = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        test_reset;
        test_single_add;
        test_all_four;
        test_fairness;
        test_back_to_back;
        test_reset_midflight;
        test_idle;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
